// File: rtl/shl_seq_if.sv
// shl_seq_if: request/response bundle for the sequential left shifter.
// master drives the operand side; slave (the shifter) drives the result side.
interface shl_seq_if #(
    parameter int WIDTH   = 4,
    parameter int SHAMT_W = 3
);
    logic               start;
    logic [WIDTH-1:0]   in;
    logic [SHAMT_W-1:0] shamt;
    logic               fill;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   out;
    logic               ovf;
    modport master (output start, in, shamt, fill, input busy, done, out, ovf);
    modport slave  (input start, in, shamt, fill, output busy, done, out, ovf);
endinterface

// File: rtl/shl_seq.sv
// shl_seq: sequential left shifter, one bit position per clock, done pulse on completion.
// Define SHL_OVF_DETECT_EN to build the sticky signed-overflow detector; otherwise ovf is 0.
module shl_seq #(
    parameter int WIDTH   = 4,
    parameter int SHAMT_W = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    shl_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t             r_state;
    logic [WIDTH-1:0]   r_data;
    logic [SHAMT_W-1:0] r_count;
    logic               r_fill;
    logic               w_accept;
    logic               w_step;
    assign w_accept = bus.start && (r_state != SHIFT);
    assign w_step   = !w_accept && (r_state == SHIFT);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_count <= '0;
            r_fill  <= 1'b0;
        end else if (w_accept) begin
            r_data  <= bus.in;
            r_count <= bus.shamt;
            r_fill  <= bus.fill;
            r_state <= (bus.shamt == '0) ? DONE : SHIFT;
        end else if (w_step) begin
            r_data  <= {r_data[WIDTH-2:0], r_fill};
            r_count <= r_count - SHAMT_W'(1);
            r_state <= (r_count == SHAMT_W'(1)) ? DONE : SHIFT;
        end else if (r_state == DONE) begin
            r_state <= IDLE;
        end
    end
`ifdef SHL_OVF_DETECT_EN
    logic r_ovf;
    // A step flips the MSB exactly when the two top bits differ before it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ovf <= 1'b0;
        else if (w_accept) r_ovf <= 1'b0;
        else if (w_step) r_ovf <= r_ovf | (r_data[WIDTH-1] ^ r_data[WIDTH-2]);
    end
    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = 1'b0;
`endif
    assign bus.busy = (r_state == SHIFT);
    assign bus.done = (r_state == DONE);
    assign bus.out  = r_data;
endmodule

// File: tb/tb_shl_seq.sv
// tb_shl_seq: directed vectors for shl_seq; driver queues expectations, negedge monitor checks on done.
module tb_shl_seq;
`ifdef SHL_OVF_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    typedef struct {
        logic [3:0] out;
        logic       ovf;
        int         cyc;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];
    shl_seq_if #(.WIDTH(4), .SHAMT_W(3)) bus ();
    shl_seq #(.WIDTH(4), .SHAMT_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out", int'(bus.out), int'(e.out));
                chk("ovf", int'(bus.ovf), int'(e.ovf));
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end
    task automatic push(input logic [3:0] eo, input logic eovf, input int lat);
        exp_t e;
        e.out = eo;
        e.ovf = eovf & OVF_EN;
        e.cyc = cyc + lat;
        sb.push_back(e);
    endtask
    task automatic op(input logic [3:0] a, input logic [2:0] s, input logic f,
                      input logic [3:0] eo, input logic eovf, input bit poke);
        int  nb;
        bit  seen;
        nb = 0;
        seen = 0;
        @(negedge clk);
        bus.in = a; bus.shamt = s; bus.fill = f; bus.start = 1'b1;
        @(posedge clk); #1;
        push(eo, eovf, int'(s));
        bus.start = 1'b0; bus.in = ~a; bus.shamt = 3'd0; bus.fill = ~f;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) begin seen = 1; break; end
            if (bus.busy) nb++;
            bus.start = (poke && i == 1);
        end
        bus.start = 1'b0;
        chk("done_seen", int'(seen), 1);
        chk("busy_cycles", nb, int'(s));
    endtask
    initial begin
        bus.start = 1'b0; bus.in = '0; bus.shamt = '0; bus.fill = 1'b0;
        #12;
        chk("rst_out", int'(bus.out), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_ovf", int'(bus.ovf), 0);
        @(negedge clk); rst_n = 1'b1;
        // abort mid-shift with an async reset; no done may follow
        @(negedge clk);
        bus.in = 4'b0011; bus.shamt = 3'd3; bus.fill = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        @(negedge clk);
        chk("pre_abort_busy", int'(bus.busy), 1);
        rst_n = 1'b0; #1;
        chk("abort_out", int'(bus.out), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_ovf", int'(bus.ovf), 0);
        @(negedge clk); rst_n = 1'b1;
        op(4'b1010, 3'd1, 1'b0, 4'b0100, 1'b1, 0);
        op(4'b0011, 3'd2, 1'b0, 4'b1100, 1'b1, 0);
        op(4'b0001, 3'd2, 1'b0, 4'b0100, 1'b0, 0);
        op(4'b1001, 3'd0, 1'b0, 4'b1001, 1'b0, 0);
        op(4'b0110, 3'd5, 1'b1, 4'b1111, 1'b1, 1);
        op(4'b1000, 3'd2, 1'b1, 4'b0011, 1'b1, 0);
        op(4'b1111, 3'd7, 1'b0, 4'b0000, 1'b1, 0);
        // start held across SHIFT (ignored) and into DONE (reloaded with no gap)
        @(negedge clk);
        bus.in = 4'b0011; bus.shamt = 3'd1; bus.fill = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        push(4'b0110, 1'b0, 1);
        bus.in = 4'b0001; bus.shamt = 3'd0;
        @(posedge clk);
        @(posedge clk); #1;
        push(4'b0001, 1'b0, 0);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
